div_operand_sequencer: RTL and testbench

//  Upstream feeder for the repeated-subtraction divider (datapath + controlpath pair).

---
 rtl/div_operand_sequencer_if.sv | 34 +++
 rtl/div_operand_sequencer.sv | 145 ++++++++++++++
 tb/tb_div_operand_sequencer.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/div_operand_sequencer_if.sv
// Bundle of the operand, result and divider-side buses around div_operand_sequencer.
// slave is the sequencer's view; master is the environment (producer, consumer, divider).
interface div_operand_sequencer_if #(
  parameter int unsigned WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_dividend;
  logic [WIDTH-1:0] in_divisor;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_quot;
  logic [WIDTH-1:0] out_rem;
  logic             out_dbz;
  logic             out_timeout;
  logic             busy;
  logic             div_start;
  logic [WIDTH-1:0] div_data;
  logic             div_done;
  logic [WIDTH-1:0] div_quot;
  logic [WIDTH-1:0] div_rem;

  modport slave (
    input  in_valid, in_dividend, in_divisor, out_ready, div_done, div_quot, div_rem,
    output in_ready, out_valid, out_quot, out_rem, out_dbz, out_timeout, busy,
           div_start, div_data
  );

  modport master (
    output in_valid, in_dividend, in_divisor, out_ready, div_done, div_quot, div_rem,
    input  in_ready, out_valid, out_quot, out_rem, out_dbz, out_timeout, busy,
           div_start, div_data
  );
endinterface

// File: rtl/div_operand_sequencer.sv
// Feeds a repeated-subtraction divider: serialises divisor then dividend onto div_data,
// pulses start, collects the result; traps divide-by-zero and aborts on timeout.
module div_operand_sequencer #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned LOAD_CYC = 2,
  parameter int unsigned TIMEOUT  = 70000,
  parameter int unsigned TO_W     = 17
) (
  input  logic                   clk,
  input  logic                   rst_n,
  div_operand_sequencer_if.slave bus
);
  localparam int unsigned     LC_W    = (LOAD_CYC > 1) ? $clog2(LOAD_CYC) : 1;
  localparam logic [LC_W-1:0] LC_LAST = LC_W'(LOAD_CYC - 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LD_DVS,
    S_LD_DVD,
    S_WAIT,
    S_RESP
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [LC_W-1:0]  r_ld_cnt;
  logic [TO_W-1:0]  r_to_cnt;
  logic [WIDTH-1:0] r_dividend;
  logic             r_div_start;
  logic [WIDTH-1:0] r_div_data;
  logic             r_out_valid;
  logic             r_out_dbz;
  logic             r_out_timeout;
  logic [WIDTH-1:0] r_out_quot;
  logic [WIDTH-1:0] r_out_rem;
  logic             w_accept;
  logic             w_dbz;
  logic             w_ld_last;
  logic             w_to_hit;

  assign w_accept  = bus.in_valid && (r_state == S_IDLE);
  assign w_dbz     = (bus.in_divisor == '0);
  assign w_ld_last = (r_ld_cnt == LC_LAST);
  assign w_to_hit  = (r_to_cnt == TO_LAST);

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:   if (w_accept) w_state_nxt = w_dbz ? S_RESP : S_LD_DVS;
      S_LD_DVS: if (w_ld_last) w_state_nxt = S_LD_DVD;
      S_LD_DVD: if (w_ld_last) w_state_nxt = S_WAIT;
      S_WAIT:   if (bus.div_done || w_to_hit) w_state_nxt = S_RESP;
      S_RESP:   if (bus.out_ready) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Counters restart on every state change, so both begin at zero on entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ld_cnt <= '0;
      r_to_cnt <= '0;
    end else begin
      if (r_state != w_state_nxt)
        r_ld_cnt <= '0;
      else if (r_state == S_LD_DVS || r_state == S_LD_DVD)
        r_ld_cnt <= r_ld_cnt + LC_W'(1);
      if (r_state == S_WAIT && w_state_nxt == S_WAIT)
        r_to_cnt <= r_to_cnt + TO_W'(1);
      else
        r_to_cnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dividend    <= '0;
      r_div_start   <= 1'b0;
      r_div_data    <= '0;
      r_out_valid   <= 1'b0;
      r_out_dbz     <= 1'b0;
      r_out_timeout <= 1'b0;
      r_out_quot    <= '0;
      r_out_rem     <= '0;
    end else begin
      r_div_start <= 1'b0;
      r_out_valid <= (w_state_nxt == S_RESP);
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_dividend <= bus.in_dividend;
            if (w_dbz) begin
              r_out_dbz     <= 1'b1;
              r_out_timeout <= 1'b0;
              r_out_quot    <= '1;
              r_out_rem     <= bus.in_dividend;
            end else begin
              // div_data itself holds the captured divisor through LD_DVS
              r_div_start <= 1'b1;
              r_div_data  <= bus.in_divisor;
            end
          end
        end
        S_LD_DVS: if (w_ld_last) r_div_data <= r_dividend;
        S_WAIT: begin
          if (bus.div_done) begin
            r_out_quot    <= bus.div_quot;
            r_out_rem     <= bus.div_rem;
            r_out_dbz     <= 1'b0;
            r_out_timeout <= 1'b0;
          end else if (w_to_hit) begin
            r_out_quot    <= '0;
            r_out_rem     <= '0;
            r_out_dbz     <= 1'b0;
            r_out_timeout <= 1'b1;
          end
        end
        S_RESP: begin
          if (bus.out_ready) begin
            r_out_dbz     <= 1'b0;
            r_out_timeout <= 1'b0;
            r_div_data    <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready    = (r_state == S_IDLE);
  assign bus.busy        = (r_state != S_IDLE);
  assign bus.div_start   = r_div_start;
  assign bus.div_data    = r_div_data;
  assign bus.out_valid   = r_out_valid;
  assign bus.out_dbz     = r_out_dbz;
  assign bus.out_timeout = r_out_timeout;
  assign bus.out_quot    = r_out_quot;
  assign bus.out_rem     = r_out_rem;
endmodule

// File: tb/tb_div_operand_sequencer.sv
// Bench for div_operand_sequencer: behavioural divider model, vector table, and
// hand-written sequences for stray done, reset mid-operation and result hold.
module tb_div_operand_sequencer;
  localparam int unsigned W  = 16;
  localparam int unsigned LC = 2;
  localparam int unsigned TO = 50;
  localparam int          NV = 11;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  div_operand_sequencer_if #(.WIDTH(W)) bus ();

  div_operand_sequencer #(
    .WIDTH   (W),
    .LOAD_CYC(LC),
    .TIMEOUT (TO),
    .TO_W    (6)
  ) u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Divider model: latches divisor on start, dividend LC edges later, raises done
  // (level, cleared by the next start) at cycle m_done_at after the start cycle; 0 = never.
  int         m_k       = 0;
  int         m_done_at = 0;
  logic [W-1:0] m_dvs   = 16'd1;
  logic [W-1:0] m_dvd   = '0;
  logic       m_done    = 1'b0;
  logic       m_glitch  = 1'b0;

  always @(posedge clk) begin
    if (bus.div_start === 1'b1) begin
      m_k    <= 1;
      m_dvs  <= bus.div_data;
      m_done <= 1'b0;
    end else if (m_k > 0) begin
      m_k <= m_k + 1;
      if (m_k == LC) m_dvd <= bus.div_data;
      if (m_done_at != 0 && m_k == m_done_at - 1) m_done <= 1'b1;
    end
  end

  assign bus.div_done = m_done | m_glitch;
  assign bus.div_quot = m_done ? (m_dvd / m_dvs) : '0;
  assign bus.div_rem  = m_done ? (m_dvd % m_dvs) : '0;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [W-1:0] dvd;
    logic [W-1:0] dvs;
    int           done_at;
    int           hold;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
    logic         to;
    int           lat;
  } vec_t;

  vec_t vecs[NV];

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic handshake(input string tag);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk($sformatf("%s.valid_drop", tag), bus.out_valid, 0);
    chk($sformatf("%s.ready_back", tag), bus.in_ready, 1);
    chk($sformatf("%s.flags_drop", tag), {bus.out_dbz, bus.out_timeout}, 0);
    chk($sformatf("%s.data_idle", tag), bus.div_data, 0);
  endtask

  task automatic run_op(input vec_t v, input string tag);
    int cnt, starts, start_at, bad_rdy, bad_data, bad_hold;
    bit got;
    logic [W-1:0] exp_data, hq, hr;
    cnt = 0; starts = 0; start_at = -1; bad_rdy = 0; bad_data = 0; bad_hold = 0; got = 0;
    m_done_at = v.done_at;
    @(negedge clk);
    chk($sformatf("%s.in_ready", tag), bus.in_ready, 1);
    bus.in_valid    = 1'b1;
    bus.in_dividend = v.dvd;
    bus.in_divisor  = v.dvs;
    while (!got && cnt < 200) begin
      @(negedge clk);
      cnt++;
      if (cnt == 1) begin
        bus.in_valid    = 1'b0;
        bus.in_dividend = '0;
        bus.in_divisor  = '0;
      end
      if (bus.div_start === 1'b1) begin
        starts++;
        start_at = cnt;
      end
      if (bus.in_ready !== 1'b0 || bus.busy !== 1'b1) bad_rdy++;
      if (bus.out_valid === 1'b1) got = 1;
      else begin
        exp_data = (v.dvs == '0) ? '0 : (cnt <= LC) ? v.dvs : v.dvd;
        if (bus.div_data !== exp_data) bad_data++;
      end
    end
    chk($sformatf("%s.got_valid", tag), got, 1);
    if (!got) begin
      pulse_reset();
      return;
    end
    chk($sformatf("%s.latency", tag), cnt, v.lat);
    chk($sformatf("%s.start_count", tag), starts, (v.dvs == '0) ? 0 : 1);
    if (v.dvs != '0) chk($sformatf("%s.start_cycle", tag), start_at, 1);
    chk($sformatf("%s.busy_noready", tag), bad_rdy, 0);
    chk($sformatf("%s.div_data_seq", tag), bad_data, 0);
    chk($sformatf("%s.quot", tag), bus.out_quot, v.q);
    chk($sformatf("%s.rem", tag), bus.out_rem, v.r);
    chk($sformatf("%s.dbz", tag), bus.out_dbz, v.dbz);
    chk($sformatf("%s.timeout", tag), bus.out_timeout, v.to);
    if (v.hold > 0) begin
      hq = bus.out_quot;
      hr = bus.out_rem;
      repeat (v.hold) begin
        @(negedge clk);
        if (bus.out_valid !== 1'b1 || bus.out_quot !== hq || bus.out_rem !== hr ||
            bus.out_dbz !== v.dbz || bus.out_timeout !== v.to || bus.in_ready !== 1'b0)
          bad_hold++;
      end
      chk($sformatf("%s.hold_stable", tag), bad_hold, 0);
    end
    handshake(tag);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk($sformatf("%s.in_ready", tag), bus.in_ready, 1);
    chk($sformatf("%s.busy", tag), bus.busy, 0);
    chk($sformatf("%s.out_valid", tag), bus.out_valid, 0);
    chk($sformatf("%s.div_start", tag), bus.div_start, 0);
    chk($sformatf("%s.div_data", tag), bus.div_data, 0);
    chk($sformatf("%s.flags", tag), {bus.out_dbz, bus.out_timeout}, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    bit got;
    rst_n           = 1'b0;
    bus.in_valid    = 1'b0;
    bus.in_dividend = '0;
    bus.in_divisor  = '0;
    bus.out_ready   = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    chk("reset.quot_rem", {bus.out_quot, bus.out_rem}, 0);
    rst_n = 1'b1;

    // Stray done while idle must not start anything.
    @(negedge clk);
    m_glitch = 1'b1;
    @(negedge clk);
    m_glitch = 1'b0;
    chk("idle_done.in_ready", bus.in_ready, 1);
    chk("idle_done.out_valid", bus.out_valid, 0);

    //           dvd       dvs    done hold  quot      rem      dbz   to    lat
    vecs[0]  = '{16'd4,     16'd3,  8,  0, 16'd1,     16'd1,    1'b0, 1'b0, 10};
    vecs[1]  = '{16'd100,   16'd7,  8,  0, 16'd14,    16'd2,    1'b0, 1'b0, 10};
    vecs[2]  = '{16'd65535, 16'd1,  8,  0, 16'd65535, 16'd0,    1'b0, 1'b0, 10};
    vecs[3]  = '{16'h1234,  16'd0,  0,  0, 16'hFFFF,  16'h1234, 1'b1, 1'b0, 1};
    vecs[4]  = '{16'd1000,  16'd33, 8,  5, 16'd30,    16'd10,   1'b0, 1'b0, 10};
    vecs[5]  = '{16'd7,     16'd3,  0,  0, 16'd0,     16'd0,    1'b0, 1'b1, 55};
    vecs[6]  = '{16'd4,     16'd3,  53, 0, 16'd1,     16'd1,    1'b0, 1'b0, 55};
    vecs[7]  = '{16'd50,    16'd6,  54, 0, 16'd0,     16'd0,    1'b0, 1'b1, 55};
    vecs[8]  = '{16'd0,     16'd5,  5,  0, 16'd0,     16'd0,    1'b0, 1'b0, 7};
    vecs[9]  = '{16'd0,     16'd0,  0,  2, 16'hFFFF,  16'd0,    1'b1, 1'b0, 1};
    vecs[10] = '{16'd3,     16'd9,  4,  0, 16'd0,     16'd3,    1'b0, 1'b0, 6};
    for (int i = 0; i < NV; i++) run_op(vecs[i], $sformatf("v%0d", i));

    // Stray done during LD_DVS: sequencing continues and the real result is used.
    m_done_at = 8;
    @(negedge clk);
    bus.in_valid    = 1'b1;
    bus.in_dividend = 16'd30;
    bus.in_divisor  = 16'd4;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    m_glitch = 1'b1;
    @(negedge clk);
    m_glitch = 1'b0;
    chk("ld_done.div_data", bus.div_data, 30);
    chk("ld_done.out_valid", bus.out_valid, 0);
    cnt = 3; got = 0;
    while (!got && cnt < 200) begin
      @(negedge clk);
      cnt++;
      if (bus.out_valid === 1'b1) got = 1;
    end
    chk("ld_done.latency", cnt, 10);
    chk("ld_done.quot", bus.out_quot, 7);
    chk("ld_done.rem", bus.out_rem, 2);
    handshake("ld_done");

    // Reset during LD_DVD, then during WAIT; no result may surface afterwards.
    for (int k = 0; k < 2; k++) begin
      m_done_at = (k == 0) ? 8 : 0;
      @(negedge clk);
      bus.in_valid    = 1'b1;
      bus.in_dividend = 16'd20;
      bus.in_divisor  = 16'd3;
      @(negedge clk);
      bus.in_valid = 1'b0;
      repeat ((k == 0) ? 2 : 6) @(negedge clk);
      chk($sformatf("rst%0d.pre_data", k), bus.div_data, 20);
      rst_n = 1'b0;
      #1;
      check_reset_outputs($sformatf("rst%0d", k));
      @(negedge clk);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      chk($sformatf("rst%0d.no_result", k), bus.out_valid, 0);
      chk($sformatf("rst%0d.idle", k), bus.in_ready, 1);
    end
    run_op('{16'd9, 16'd2, 8, 0, 16'd4, 16'd1, 1'b0, 1'b0, 10}, "post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
